// File: rtl/amo_unit_if.sv
// amo_unit_if: bundles the EX-stage request/response handshake, the
// data-memory request port, and the reservation snoop/flush inputs.
//   slave  : the amo_unit side (consumes i_*, drives o_*)
//   master : the EX stage / memory / coherence side (drives i_*, consumes o_*)
interface amo_unit_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 32
);
  // EX-stage request
  logic              i_req_valid;
  logic              o_req_ready;
  logic [4:0]        i_op;
  logic              i_word;
  logic [ADDR_W-1:0] i_addr;
  logic [XLEN-1:0]   i_rs2;
  // EX-stage response
  logic              o_resp_valid;
  logic              i_resp_ready;
  logic [XLEN-1:0]   o_rd;
  logic              o_err;
  logic              o_err_bus;
  // data-memory port
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [XLEN-1:0]   o_mem_wdata;
  logic [XLEN/8-1:0] o_mem_be;
  logic              i_mem_ack;
  logic [XLEN-1:0]   i_mem_rdata;
  logic              i_mem_err;
  // reservation maintenance
  logic              i_snoop_valid;
  logic [ADDR_W-1:0] i_snoop_addr;
  logic              i_flush;

  modport slave (
    input  i_req_valid, i_op, i_word, i_addr, i_rs2, i_resp_ready,
           i_mem_ack, i_mem_rdata, i_mem_err, i_snoop_valid, i_snoop_addr, i_flush,
    output o_req_ready, o_resp_valid, o_rd, o_err, o_err_bus,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );

  modport master (
    output i_req_valid, i_op, i_word, i_addr, i_rs2, i_resp_ready,
           i_mem_ack, i_mem_rdata, i_mem_err, i_snoop_valid, i_snoop_addr, i_flush,
    input  o_req_ready, o_resp_valid, o_rd, o_err, o_err_bus,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );
endinterface

// File: rtl/amo_unit.sv
// amo_unit: sequential RV-A execution unit. Runs LR/SC and AMO
// read-modify-write ops against a single data-memory port and holds the
// hart's LR reservation. .W ops on RV64 use one 32-bit lane, sign-extended.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : amo_unit_if.slave (request/response, memory port, snoop/flush)
module amo_unit #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned RES_GRAN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  amo_unit_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;
  localparam int unsigned GW     = ADDR_W - RES_GRAN;

  state_e            state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   rs2_q, rs2_d, mem_q, mem_d, rd_q, rd_d;
  logic              err_q, err_d, err_bus_q, err_bus_d;
  logic              resv_valid_q, resv_valid_d;
  logic [GW-1:0]     resv_gran_q, resv_gran_d;

  logic              req_word, misaligned, snoop_hit, sc_ok, lr_clear, hi_lane;
  logic [31:0]       word_lane;
  logic [XLEN-1:0]   rd_lane, opb, alu_res, wdata_lane;
  logic [XLEN/8-1:0] be_lane;

  assign req_word   = (XLEN == 32) || bus.i_word;
  assign misaligned = req_word ? (bus.i_addr[1:0] != 2'b00) : (bus.i_addr[2:0] != 3'b000);
  assign snoop_hit  = resv_valid_q && bus.i_snoop_valid &&
                      (bus.i_snoop_addr[ADDR_W-1:RES_GRAN] == resv_gran_q);
  assign sc_ok      = resv_valid_q && !snoop_hit &&
                      (bus.i_addr[ADDR_W-1:RES_GRAN] == resv_gran_q);
  // A clear arriving in the LR read-ack cycle must beat the reservation set,
  // so compare the snoop against the LR's own granule, not the old one.
  assign lr_clear   = bus.i_flush || (bus.i_snoop_valid &&
                      (bus.i_snoop_addr[ADDR_W-1:RES_GRAN] == addr_q[ADDR_W-1:RES_GRAN]));

  assign hi_lane   = (XLEN == 64) && word_q && addr_q[2];
  assign word_lane = 32'(bus.i_mem_rdata >> {hi_lane, 5'b0});
  // .W operands are held sign-extended; this keeps both signed and unsigned
  // 64-bit compares correct for 32-bit values and makes o_rd a plain copy.
  assign rd_lane   = word_q ? XLEN'($signed(word_lane)) : bus.i_mem_rdata;
  assign opb       = word_q ? XLEN'($signed(rs2_q[31:0])) : rs2_q;

  always_comb begin
    alu_res = opb;
    case (op_q)
      OP_ADD:  alu_res = mem_q + opb;
      OP_SWAP: alu_res = opb;
      OP_XOR:  alu_res = mem_q ^ opb;
      OP_OR:   alu_res = mem_q | opb;
      OP_AND:  alu_res = mem_q & opb;
      OP_MIN:  alu_res = ($signed(mem_q) <= $signed(opb)) ? mem_q : opb;
      OP_MAX:  alu_res = ($signed(mem_q) >= $signed(opb)) ? mem_q : opb;
      OP_MINU: alu_res = (mem_q <= opb) ? mem_q : opb;
      OP_MAXU: alu_res = (mem_q >= opb) ? mem_q : opb;
      default: alu_res = opb;
    endcase
  end

  assign wdata_lane = word_q ? (XLEN'(alu_res[31:0]) << {hi_lane, 5'b0}) : alu_res;
  assign be_lane    = word_q ? ((XLEN/8)'(4'hF) << {hi_lane, 2'b0}) : '1;

  assign bus.o_req_ready  = (state_q == S_IDLE);
  assign bus.o_resp_valid = (state_q == S_RESP);
  assign bus.o_rd         = (state_q == S_RESP) ? rd_q : '0;
  assign bus.o_err        = (state_q == S_RESP) && err_q;
  assign bus.o_err_bus    = (state_q == S_RESP) && err_bus_q;
  assign bus.o_mem_req    = (state_q == S_RD) || (state_q == S_WR);
  assign bus.o_mem_we     = (state_q == S_WR);
  assign bus.o_mem_addr   = bus.o_mem_req ? addr_q : '0;
  assign bus.o_mem_wdata  = (state_q == S_WR) ? wdata_lane : '0;
  assign bus.o_mem_be     = bus.o_mem_req ? be_lane : '0;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    word_d       = word_q;
    addr_d       = addr_q;
    rs2_d        = rs2_q;
    mem_d        = mem_q;
    rd_d         = rd_q;
    err_d        = err_q;
    err_bus_d    = err_bus_q;
    resv_valid_d = resv_valid_q;
    resv_gran_d  = resv_gran_q;
    if (snoop_hit || bus.i_flush) resv_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          op_d      = bus.i_op;
          word_d    = req_word;
          addr_d    = bus.i_addr;
          rs2_d     = bus.i_rs2;
          err_d     = 1'b0;
          err_bus_d = 1'b0;
          rd_d      = '0;
          if (misaligned) begin
            err_d        = 1'b1;
            resv_valid_d = 1'b0;
            state_d      = S_RESP;
          end else if (bus.i_op == OP_SC) begin
            resv_valid_d = 1'b0;
            if (sc_ok) begin
              state_d = S_WR;
            end else begin
              rd_d    = XLEN'(1);
              state_d = S_RESP;
            end
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (bus.i_mem_ack) begin
          if (bus.i_mem_err) begin
            err_d        = 1'b1;
            err_bus_d    = 1'b1;
            rd_d         = '0;
            resv_valid_d = 1'b0;
            state_d      = S_RESP;
          end else if (op_q == OP_LR) begin
            rd_d    = rd_lane;
            state_d = S_RESP;
            if (!lr_clear) begin
              resv_valid_d = 1'b1;
              resv_gran_d  = addr_q[ADDR_W-1:RES_GRAN];
            end
          end else begin
            mem_d   = rd_lane;
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        if (bus.i_mem_ack) begin
          if (bus.i_mem_err) begin
            err_d        = 1'b1;
            err_bus_d    = 1'b1;
            rd_d         = '0;
            resv_valid_d = 1'b0;
          end else begin
            rd_d = (op_q == OP_SC) ? '0 : mem_q;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      word_q       <= 1'b0;
      addr_q       <= '0;
      rs2_q        <= '0;
      mem_q        <= '0;
      rd_q         <= '0;
      err_q        <= 1'b0;
      err_bus_q    <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_gran_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      rs2_q        <= rs2_d;
      mem_q        <= mem_d;
      rd_q         <= rd_d;
      err_q        <= err_d;
      err_bus_q    <= err_bus_d;
      resv_valid_q <= resv_valid_d;
      resv_gran_q  <= resv_gran_d;
    end
  end
endmodule
